seg7_scan_decoder: RTL
======================

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 SHALL have parameter NDIG, default 8: number of scanned digits, 1..8.
REQ-002 SHALL have parameter STABLE, default 3: consecutive identical samples required before a capture, 1..15.
REQ-003 SHALL have port clock, input, 1: sole clock; all state on rising edge.
REQ-004 SHALL have port resetn, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port seg_in, input, 7: active-low segment lines, bit0=a .. bit6=g.
REQ-006 SHALL have port dig_sel, input, NDIG: active-high digit enables, one-hot when a digit is lit.
REQ-007 SHALL have port err_clr, input, 1: synchronous clear of err_pattern.
REQ-008 SHALL have port value, output, 4*NDIG: decoded nibbles; digit i occupies bits [4i+3:4i].
REQ-009 SHALL have port digit_ok, output, NDIG: bit i set when digit i last captured a legal hex glyph.
REQ-010 SHALL have port frame_valid, output, 1: one-cycle pulse when every digit has been captured.
REQ-011 SHALL have port err_pattern, output, 1: sticky illegal-glyph flag.

Function
REQ-012 SHALL register seg_in and dig_sel once per cycle; all outputs are registered.
REQ-013 SHALL treat a sample as lit when dig_sel is exactly one-hot; zero or multi-hot is blanking.
REQ-014 SHALL, for a lit sample equal to the previous sample (same seg_in and dig_sel), increment a dwell counter that saturates at STABLE.
REQ-015 SHALL reset the dwell counter to 1 on a lit sample differing from the previous one, and to 0 on a blanking sample.
REQ-016 SHALL capture exactly once per dwell, on the edge where the counter reaches STABLE; with STABLE=1, on the first lit sample.
REQ-017 SHALL decode glyphs (seg_in hex, value): 40=0, 79=1, 24=2, 30=3, 19=4, 12=5, 02=6, 78=7, 00=8, 10=9, 08=A, 03=B, 46=C, 21=D, 06=E, 0E=F.
REQ-018 SHALL, on a legal capture, write the nibble to the selected digit field and set that digit_ok bit.
REQ-019 SHALL, on capture of 7F (blank), clear that digit_ok bit, leave its value field unchanged and not flag an error.
REQ-020 SHALL, on any other pattern, clear that digit_ok bit, leave its value field unchanged and set err_pattern.
REQ-021 SHALL record every capture (legal, blank or illegal) in a captured mask.
REQ-022 SHALL pulse frame_valid on the same edge as the capture that completes the mask, and clear the mask on that edge.
REQ-023 SHALL let a repeated capture of an already-masked digit overwrite its value without affecting frame_valid.
REQ-024 SHALL give setting err_pattern priority when err_clr and an illegal capture coincide.

Reset
REQ-025 SHALL, while resetn=0, clear value, digit_ok, frame_valid, err_pattern, captured mask, dwell counter and sample registers.
REQ-026 SHALL discard a partial dwell or partial frame on reset; the first post-reset capture requires STABLE fresh samples.

Structure
REQ-027 SHALL keep the 16 glyph constants, the blank constant 7F and the STABLE counter width in shared package seg7_pkg.
REQ-028 SHALL use one combinational sub-module, seg7_to_nibble (7-bit in; 4-bit nibble, legal, blank out).
REQ-029 SHALL convert one-hot dig_sel to an index with a plain priority-free encoder, guarded by the one-hot check.

Verification
REQ-030 Reset, then hold dig_sel=01, seg_in=30 for 3 cycles -> on the 3rd edge value[3:0]=3, digit_ok[0]=1; no further update while held.
REQ-031 Scan digits 0..7 with glyphs 40,79,24,30,19,12,02,78, 3 cycles each -> frame_valid pulses once on digit 7's capture edge; value=0x76543210, digit_ok=FF.
REQ-032 dig_sel=04, seg_in=7E for 3 cycles -> err_pattern=1, digit_ok[2]=0, value[11:8] unchanged; err_clr for 1 cycle -> err_pattern=0.
REQ-033 dig_sel=02, seg_in=06 for 2 cycles, then dig_sel=00 for 1 cycle, then 06 for 2 cycles -> no capture; 3rd consecutive sample -> value[7:4]=E.
REQ-034 dig_sel=03 (multi-hot) with seg_in=00 for 10 cycles -> no capture, no error, mask unchanged.
REQ-035 resetn low mid-frame after 5 digits captured -> all outputs 0; a full 8-digit scan is then needed before frame_valid.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan decoder: glyph patterns
// (active-low, bit0=a .. bit6=g), the blank pattern and field widths.
package seg7_pkg;

  localparam int unsigned SEG_W   = 7;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned DWELL_W = 4;

  localparam logic [SEG_W-1:0] GLYPH_0     = 7'h40;
  localparam logic [SEG_W-1:0] GLYPH_1     = 7'h79;
  localparam logic [SEG_W-1:0] GLYPH_2     = 7'h24;
  localparam logic [SEG_W-1:0] GLYPH_3     = 7'h30;
  localparam logic [SEG_W-1:0] GLYPH_4     = 7'h19;
  localparam logic [SEG_W-1:0] GLYPH_5     = 7'h12;
  localparam logic [SEG_W-1:0] GLYPH_6     = 7'h02;
  localparam logic [SEG_W-1:0] GLYPH_7     = 7'h78;
  localparam logic [SEG_W-1:0] GLYPH_8     = 7'h00;
  localparam logic [SEG_W-1:0] GLYPH_9     = 7'h10;
  localparam logic [SEG_W-1:0] GLYPH_A     = 7'h08;
  localparam logic [SEG_W-1:0] GLYPH_B     = 7'h03;
  localparam logic [SEG_W-1:0] GLYPH_C     = 7'h46;
  localparam logic [SEG_W-1:0] GLYPH_D     = 7'h21;
  localparam logic [SEG_W-1:0] GLYPH_E     = 7'h06;
  localparam logic [SEG_W-1:0] GLYPH_F     = 7'h0E;
  localparam logic [SEG_W-1:0] GLYPH_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_to_nibble.sv
// Combinational glyph decoder.
//   seg    : active-low segment pattern
//   nibble : hex value of a legal glyph (0 otherwise)
//   legal  : seg is one of the 16 hex glyphs
//   blank  : seg is the all-off pattern
module seg7_to_nibble
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output logic [NIB_W-1:0] nibble,
  output logic             legal,
  output logic             blank
);

  always_comb begin
    nibble = '0;
    legal  = 1'b1;
    blank  = 1'b0;
    case (seg)
      GLYPH_0:     nibble = NIB_W'(4'h0);
      GLYPH_1:     nibble = NIB_W'(4'h1);
      GLYPH_2:     nibble = NIB_W'(4'h2);
      GLYPH_3:     nibble = NIB_W'(4'h3);
      GLYPH_4:     nibble = NIB_W'(4'h4);
      GLYPH_5:     nibble = NIB_W'(4'h5);
      GLYPH_6:     nibble = NIB_W'(4'h6);
      GLYPH_7:     nibble = NIB_W'(4'h7);
      GLYPH_8:     nibble = NIB_W'(4'h8);
      GLYPH_9:     nibble = NIB_W'(4'h9);
      GLYPH_A:     nibble = NIB_W'(4'hA);
      GLYPH_B:     nibble = NIB_W'(4'hB);
      GLYPH_C:     nibble = NIB_W'(4'hC);
      GLYPH_D:     nibble = NIB_W'(4'hD);
      GLYPH_E:     nibble = NIB_W'(4'hE);
      GLYPH_F:     nibble = NIB_W'(4'hF);
      GLYPH_BLANK: begin
        legal = 1'b0;
        blank = 1'b1;
      end
      default:     legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers hex digits from a multiplexed 7-segment display bus.
//   clock, resetn : clock, async active-low reset
//   seg_in        : active-low segment lines
//   dig_sel       : active-high digit enables (one-hot when lit)
//   err_clr       : synchronous clear of err_pattern
//   value         : decoded nibble per digit, digit i at [4i+3:4i]
//   digit_ok      : digit i last captured a legal glyph
//   frame_valid   : one-cycle pulse when every digit has been captured
//   err_pattern   : sticky illegal-glyph flag
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned NDIG   = 8,
  parameter int unsigned STABLE = 3
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [SEG_W-1:0]      seg_in,
  input  logic [NDIG-1:0]       dig_sel,
  input  logic                  err_clr,
  output logic [4*NDIG-1:0]     value,
  output logic [NDIG-1:0]       digit_ok,
  output logic                  frame_valid,
  output logic                  err_pattern
);

  localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [SEG_W-1:0]   seg_q;
  logic [NDIG-1:0]    sel_q;
  logic [DWELL_W-1:0] cnt_q, cnt_n;
  logic [NDIG-1:0]    mask_q, mask_n, mask_hit;
  logic [4*NDIG-1:0]  value_n;
  logic [NDIG-1:0]    ok_n;
  logic               fv_n, err_n;
  logic               one_hot, same, capture;
  logic [IDX_W-1:0]   idx;
  logic [NIB_W-1:0]   nibble;
  logic               legal, blank;

  seg7_to_nibble u_dec (
    .seg    (seg_in),
    .nibble (nibble),
    .legal  (legal),
    .blank  (blank)
  );

  // Lit-sample detection and OR-based index encoder (valid only when one-hot).
  always_comb begin
    one_hot = (dig_sel != '0) && ((dig_sel & (dig_sel - NDIG'(1))) == '0);
    same    = (seg_in == seg_q) && (dig_sel == sel_q);
    idx     = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (dig_sel[i]) idx = idx | IDX_W'(i);
    end
  end

  // Dwell counter; capture fires only on the edge the count first reaches STABLE.
  always_comb begin
    cnt_n   = '0;
    capture = 1'b0;
    if (one_hot) begin
      if (same) begin
        if (cnt_q != DWELL_W'(STABLE)) begin
          cnt_n   = cnt_q + DWELL_W'(1);
          capture = (cnt_n == DWELL_W'(STABLE));
        end else begin
          cnt_n = cnt_q;
        end
      end else begin
        cnt_n   = DWELL_W'(1);
        capture = (DWELL_W'(STABLE) == DWELL_W'(1));
      end
    end
  end

  // Capture effects on digit fields, mask and error flag; a set beats err_clr.
  always_comb begin
    value_n  = value;
    ok_n     = digit_ok;
    mask_n   = mask_q;
    mask_hit = mask_q;
    fv_n     = 1'b0;
    err_n    = err_pattern;
    if (err_clr) err_n = 1'b0;
    if (capture) begin
      if (legal) begin
        value_n[{idx, 2'b00} +: 4] = nibble;
        ok_n[idx]                  = 1'b1;
      end else begin
        ok_n[idx] = 1'b0;
        if (!blank) err_n = 1'b1;
      end
      mask_hit = mask_q | (NDIG'(1) << idx);
      if (mask_hit == '1) begin
        fv_n   = 1'b1;
        mask_n = '0;
      end else begin
        mask_n = mask_hit;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      seg_q       <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      mask_q      <= '0;
      value       <= '0;
      digit_ok    <= '0;
      frame_valid <= 1'b0;
      err_pattern <= 1'b0;
    end else begin
      seg_q       <= seg_in;
      sel_q       <= dig_sel;
      cnt_q       <= cnt_n;
      mask_q      <= mask_n;
      value       <= value_n;
      digit_ok    <= ok_n;
      frame_valid <= fv_n;
      err_pattern <= err_n;
    end
  end

endmodule
